// File: rtl/mp_add_seq_pkg.sv
// Shared definitions for the multi-precision add/subtract sequencer:
// limb width, legal size limit, FSM encoding and an index-width helper.
package mp_add_seq_pkg;

  localparam int LIMB_W    = 64;
  localparam int MAX_WORDS = 16;

  typedef enum logic [1:0] {
    IDLE = 2'd0,
    RUN  = 2'd1,
    DONE = 2'd2
  } state_t;

  // Limb index width: enough to count 0..words-1, never narrower than 1 bit.
  function automatic int idx_width(input int words);
    int w;
    w = $clog2(words);
    return (w < 1) ? 1 : w;
  endfunction

endpackage

// File: rtl/mp_add_seq_if.sv
// Operand/result handshake bundle for mp_add_seq. The master side offers
// operands and consumes results; the slave side is the sequencer.
interface mp_add_seq_if
  import mp_add_seq_pkg::*;
#(
  parameter int WORDS = 4
) ();

  localparam int W = LIMB_W * WORDS;

  logic         in_valid;
  logic         in_ready;
  logic [W-1:0] a;
  logic [W-1:0] b;
  logic         c_in;
  logic         sub;
  logic         out_valid;
  logic         out_ready;
  logic [W-1:0] s;
  logic         c_out;
  logic         ovf;

  modport master (
    output in_valid, a, b, c_in, sub, out_ready,
    input  in_ready, out_valid, s, c_out, ovf
  );

  modport slave (
    input  in_valid, a, b, c_in, sub, out_ready,
    output in_ready, out_valid, s, c_out, ovf
  );

endinterface

// File: rtl/mp_add_seq_csa.sv
// 64-bit carry-select adder: four 16-bit blocks, each precomputing its sum
// for both possible carry-ins; the rippling block carry picks one.
module CSA_64_str (
  input  logic [63:0] a,
  input  logic [63:0] b,
  input  logic        c_in,
  output logic [63:0] s,
  output logic        c_out
);

  localparam int BLK = 16;
  localparam int NB  = 64 / BLK;

  logic [NB:0] blk_cy;

  assign blk_cy[0] = c_in;

  for (genvar g = 0; g < NB; g++) begin : g_blk
    logic [BLK:0] sum0;
    logic [BLK:0] sum1;

    assign sum0 = {1'b0, a[g*BLK +: BLK]} + {1'b0, b[g*BLK +: BLK]};
    assign sum1 = {1'b0, a[g*BLK +: BLK]} + {1'b0, b[g*BLK +: BLK]} + {{BLK{1'b0}}, 1'b1};

    assign s[g*BLK +: BLK] = blk_cy[g] ? sum1[BLK-1:0] : sum0[BLK-1:0];
    assign blk_cy[g+1]     = blk_cy[g] ? sum1[BLK]     : sum0[BLK];
  end

  assign c_out = blk_cy[NB];

endmodule

// File: rtl/mp_add_seq.sv
// Multi-precision adder/subtractor: streams WORDS 64-bit limbs, LS limb
// first, through one 64-bit carry-select adder, keeping the inter-limb carry
// in a register. Subtraction is a + ~b + 1.
module mp_add_seq
  import mp_add_seq_pkg::*;
#(
  parameter int WORDS = 4
) (
  input  logic         clk,
  input  logic         rst,
  mp_add_seq_if.slave  bus
);

  localparam int W     = LIMB_W * WORDS;
  localparam int IDX_W = idx_width(WORDS);

  state_t           state_q, state_d;
  logic [IDX_W-1:0] idx_q, idx_d;
  logic             carry_q, carry_d;
  logic [W-1:0]     a_q, a_d;
  logic [W-1:0]     b_q, b_d;
  logic             sub_q, sub_d;
  logic [W-1:0]     s_q, s_d;
  logic             c_out_q, c_out_d;
  logic             ovf_q, ovf_d;

  logic [LIMB_W-1:0] a_limb;
  logic [LIMB_W-1:0] b_limb;
  logic [LIMB_W-1:0] b_word;
  logic [LIMB_W-1:0] sum;
  logic              cy;
  logic              last_limb;

  // Pick the current limb of each captured operand; invert B for subtract.
  always_comb begin
    a_limb = '0;
    b_limb = '0;
    for (int i = 0; i < WORDS; i++) begin
      if (idx_q == IDX_W'(i)) begin
        a_limb = a_q[i*LIMB_W +: LIMB_W];
        b_limb = b_q[i*LIMB_W +: LIMB_W];
      end
    end
    b_word    = sub_q ? ~b_limb : b_limb;
    last_limb = (idx_q == IDX_W'(WORDS - 1));
  end

  CSA_64_str u_csa (
    .a     (a_limb),
    .b     (b_word),
    .c_in  (carry_q),
    .s     (sum),
    .c_out (cy)
  );

  // Next-state and datapath updates for the IDLE/RUN/DONE sequencer.
  always_comb begin
    state_d = state_q;
    idx_d   = idx_q;
    carry_d = carry_q;
    a_d     = a_q;
    b_d     = b_q;
    sub_d   = sub_q;
    s_d     = s_q;
    c_out_d = c_out_q;
    ovf_d   = ovf_q;
    unique case (state_q)
      IDLE: begin
        if (bus.in_valid) begin
          a_d     = bus.a;
          b_d     = bus.b;
          sub_d   = bus.sub;
          carry_d = bus.sub ? 1'b1 : bus.c_in;
          idx_d   = '0;
          state_d = RUN;
        end
      end
      RUN: begin
        for (int i = 0; i < WORDS; i++) begin
          if (idx_q == IDX_W'(i)) begin
            s_d[i*LIMB_W +: LIMB_W] = sum;
          end
        end
        carry_d = cy;
        if (last_limb) begin
          c_out_d = cy;
          ovf_d   = (a_limb[LIMB_W-1] == b_word[LIMB_W-1]) &&
                    (sum[LIMB_W-1] != a_limb[LIMB_W-1]);
          idx_d   = '0;
          state_d = DONE;
        end else begin
          idx_d = idx_q + IDX_W'(1);
        end
      end
      DONE: begin
        if (bus.out_ready) begin
          state_d = IDLE;
        end
      end
      default: begin
        state_d = IDLE;
      end
    endcase
  end

  // State and datapath registers; reset aborts any operation in flight.
  always_ff @(posedge clk or posedge rst) begin
    if (rst) begin
      state_q <= IDLE;
      idx_q   <= '0;
      carry_q <= 1'b0;
      a_q     <= '0;
      b_q     <= '0;
      sub_q   <= 1'b0;
      s_q     <= '0;
      c_out_q <= 1'b0;
      ovf_q   <= 1'b0;
    end else begin
      state_q <= state_d;
      idx_q   <= idx_d;
      carry_q <= carry_d;
      a_q     <= a_d;
      b_q     <= b_d;
      sub_q   <= sub_d;
      s_q     <= s_d;
      c_out_q <= c_out_d;
      ovf_q   <= ovf_d;
    end
  end

  assign bus.in_ready  = (state_q == IDLE);
  assign bus.out_valid = (state_q == DONE);
  assign bus.s         = s_q;
  assign bus.c_out     = c_out_q;
  assign bus.ovf       = ovf_q;

endmodule

// File: tb/tb_mp_add_seq.sv
// Bench for mp_add_seq (WORDS=4): directed vector table, randomized ops
// against an arithmetic reference, backpressure, mid-op reset, throughput.
module tb_mp_add_seq;

  localparam int WORDS = 4;
  localparam int W     = 64 * WORDS;

  logic clk;
  logic rst;

  mp_add_seq_if #(.WORDS(WORDS)) bus ();

  mp_add_seq #(.WORDS(WORDS)) dut (
    .clk (clk),
    .rst (rst),
    .bus (bus)
  );

  initial clk = 1'b0;
  always #5 clk = ~clk;

  int pass_cnt  = 0;
  int total_cnt = 0;

  typedef struct {
    logic [W-1:0] a;
    logic [W-1:0] b;
    logic         cin;
    logic         sub;
    logic [W-1:0] es;
    logic         ec;
    logic         eovf;
  } vec_t;

  vec_t tbl[7];

  task automatic check_s(input string name, input logic [W-1:0] got, input logic [W-1:0] exp);
    total_cnt++;
    if (got === exp) pass_cnt++;
    else $display("FAIL %s: got %h expected %h", name, got, exp);
  endtask

  task automatic check_bit(input string name, input logic got, input logic exp);
    total_cnt++;
    if (got === exp) pass_cnt++;
    else $display("FAIL %s: got %b expected %b", name, got, exp);
  endtask

  task automatic check_int(input string name, input int got, input int exp);
    total_cnt++;
    if (got == exp) pass_cnt++;
    else $display("FAIL %s: got %0d expected %0d", name, got, exp);
  endtask

  // Reference: signed/unsigned arithmetic on the whole W-bit operands.
  task automatic model(input logic [W-1:0] a, input logic [W-1:0] b,
                       input logic cin, input logic sub,
                       output logic [W-1:0] es, output logic ec, output logic eovf);
    logic signed [W+1:0] sa, sb, sc, r;
    logic [W:0] ua;
    sa = {{2{a[W-1]}}, a};
    sb = {{2{b[W-1]}}, b};
    sc = {{(W+1){1'b0}}, cin};
    r  = sub ? (sa - sb) : (sa + sb + sc);
    es = r[W-1:0];
    eovf = !((r[W+1] == r[W-1]) && (r[W] == r[W-1]));
    ua = {1'b0, a} + {1'b0, b} + {{W{1'b0}}, cin};
    ec = sub ? (a >= b) : ua[W];
  endtask

  // Issue one operation and collect its result; entered/left at #1 after a posedge.
  task automatic run_op(input logic [W-1:0] ta, input logic [W-1:0] tb_v,
                        input logic tcin, input logic tsub,
                        output logic [W-1:0] rs, output logic rc, output logic rovf,
                        output int lat);
    int guard;
    guard = 0;
    while (!bus.in_ready && guard < 50) begin
      @(posedge clk); #1; guard++;
    end
    bus.a = ta; bus.b = tb_v; bus.c_in = tcin; bus.sub = tsub;
    bus.in_valid = 1'b1;
    @(posedge clk); #1;
    bus.in_valid = 1'b0;
    bus.a = ~ta; bus.b = ~tb_v; bus.c_in = ~tcin; bus.sub = ~tsub;
    lat = 0;
    while (!bus.out_valid && lat < 50) begin
      @(posedge clk); #1; lat++;
    end
    rs = bus.s; rc = bus.c_out; rovf = bus.ovf;
    bus.out_ready = 1'b1;
    @(posedge clk); #1;
    bus.out_ready = 1'b0;
  endtask

  initial begin
    #200000;
    $display("FAIL watchdog: got timeout expected finish");
    $fatal(1, "watchdog expired");
  end

  initial begin
    logic [W-1:0] all1, maxpos, minneg, rs, ra, rb, es;
    logic rc, rovf, ec, eovf, rcin, rsub;
    int lat, guard, nacc;
    int acc[$];

    all1   = '1;
    maxpos = {1'b0, {(W-1){1'b1}}};
    minneg = {1'b1, {(W-1){1'b0}}};

    tbl[0] = '{all1, 256'd1, 1'b0, 1'b0, 256'd0, 1'b1, 1'b0};
    tbl[1] = '{256'd0, 256'd0, 1'b1, 1'b0, 256'd1, 1'b0, 1'b0};
    tbl[2] = '{256'd5, 256'd3, 1'b1, 1'b1, 256'd2, 1'b1, 1'b0};
    tbl[3] = '{256'd0, 256'd1, 1'b0, 1'b1, all1, 1'b0, 1'b0};
    tbl[4] = '{maxpos, 256'd1, 1'b0, 1'b0, minneg, 1'b0, 1'b1};
    tbl[5] = '{minneg, 256'd1, 1'b0, 1'b1, maxpos, 1'b1, 1'b1};
    tbl[6] = '{{192'd0, 64'hFFFF_FFFF_FFFF_FFFF}, 256'd1, 1'b0, 1'b0,
               {191'd0, 1'b1, 64'd0}, 1'b0, 1'b0};

    bus.in_valid = 1'b0; bus.out_ready = 1'b0;
    bus.a = '0; bus.b = '0; bus.c_in = 1'b0; bus.sub = 1'b0;
    rst = 1'b1;
    #1;
    check_bit("rst_in_ready", bus.in_ready, 1'b1);
    check_bit("rst_out_valid", bus.out_valid, 1'b0);
    check_s("rst_s", bus.s, '0);
    check_bit("rst_c_out", bus.c_out, 1'b0);
    check_bit("rst_ovf", bus.ovf, 1'b0);
    @(negedge clk); @(negedge clk);
    rst = 1'b0;
    @(posedge clk); #1;

    // Directed vectors
    for (int i = 0; i < 7; i++) begin
      run_op(tbl[i].a, tbl[i].b, tbl[i].cin, tbl[i].sub, rs, rc, rovf, lat);
      check_s($sformatf("vec%0d_s", i), rs, tbl[i].es);
      check_bit($sformatf("vec%0d_c_out", i), rc, tbl[i].ec);
      check_bit($sformatf("vec%0d_ovf", i), rovf, tbl[i].eovf);
      check_int($sformatf("vec%0d_latency", i), lat, WORDS);
    end

    // Randomized operations against the reference
    for (int n = 0; n < 24; n++) begin
      for (int k = 0; k < 8; k++) begin
        ra[k*32 +: 32] = $urandom;
        rb[k*32 +: 32] = $urandom;
      end
      rsub = $urandom_range(0, 1);
      rcin = $urandom_range(0, 1);
      case ($urandom_range(0, 3))
        0: rb = ~ra;
        1: rb = ra;
        default: ;
      endcase
      model(ra, rb, rcin, rsub, es, ec, eovf);
      run_op(ra, rb, rcin, rsub, rs, rc, rovf, lat);
      check_s($sformatf("rnd%0d_s", n), rs, es);
      check_bit($sformatf("rnd%0d_c_out", n), rc, ec);
      check_bit($sformatf("rnd%0d_ovf", n), rovf, eovf);
    end

    // Backpressure: result held while out_ready is low
    bus.a = 256'd3; bus.b = 256'd4; bus.c_in = 1'b0; bus.sub = 1'b0;
    bus.in_valid = 1'b1;
    @(posedge clk); #1;
    bus.in_valid = 1'b0;
    guard = 0;
    while (!bus.out_valid && guard < 50) begin
      @(posedge clk); #1; guard++;
    end
    check_int("bp_latency", guard, WORDS);
    for (int c = 0; c < 10; c++) begin
      bus.in_valid = $urandom_range(0, 1);
      bus.a = {8{$urandom}};
      bus.b = {8{$urandom}};
      @(posedge clk); #1;
      check_s($sformatf("bp%0d_s", c), bus.s, 256'd7);
      check_bit($sformatf("bp%0d_in_ready", c), bus.in_ready, 1'b0);
      check_bit($sformatf("bp%0d_out_valid", c), bus.out_valid, 1'b1);
    end
    check_bit("bp_c_out", bus.c_out, 1'b0);
    check_bit("bp_ovf", bus.ovf, 1'b0);
    bus.in_valid = 1'b0;
    bus.out_ready = 1'b1;
    @(posedge clk); #1;
    bus.out_ready = 1'b0;
    check_bit("bp_release_out_valid", bus.out_valid, 1'b0);
    check_bit("bp_release_in_ready", bus.in_ready, 1'b1);

    // Reset while RUN is on limb index 2
    bus.a = all1; bus.b = all1; bus.c_in = 1'b1; bus.sub = 1'b0;
    bus.in_valid = 1'b1;
    @(posedge clk); #1;
    bus.in_valid = 1'b0;
    @(posedge clk); @(posedge clk); #1;
    rst = 1'b1;
    #1;
    check_bit("midrst_out_valid", bus.out_valid, 1'b0);
    check_s("midrst_s", bus.s, '0);
    check_bit("midrst_in_ready", bus.in_ready, 1'b1);
    check_bit("midrst_c_out", bus.c_out, 1'b0);
    @(negedge clk);
    rst = 1'b0;
    @(posedge clk); #1;
    run_op(256'd1, 256'd1, 1'b0, 1'b0, rs, rc, rovf, lat);
    check_s("postrst_s", rs, 256'd2);
    check_int("postrst_latency", lat, WORDS);

    // Back-to-back: accepts spaced WORDS+2 cycles apart
    bus.a = 256'd1; bus.b = 256'd2; bus.c_in = 1'b0; bus.sub = 1'b0;
    bus.in_valid = 1'b1; bus.out_ready = 1'b1;
    nacc = 0;
    for (int c = 0; c < 40 && nacc < 4; c++) begin
      if (bus.out_valid) check_s($sformatf("b2b_s_c%0d", c), bus.s, 256'd3);
      if (bus.in_ready) begin
        acc.push_back(c);
        nacc++;
      end
      @(posedge clk); #1;
    end
    bus.in_valid = 1'b0;
    check_int("b2b_accept_count", nacc, 4);
    for (int k = 1; k < acc.size(); k++) begin
      check_int($sformatf("b2b_gap%0d", k), acc[k] - acc[k-1], WORDS + 2);
    end
    guard = 0;
    while (!bus.out_valid && guard < 50) begin
      @(posedge clk); #1; guard++;
    end
    check_s("b2b_last_s", bus.s, 256'd3);
    @(posedge clk); #1;
    bus.out_ready = 1'b0;
    check_bit("b2b_final_in_ready", bus.in_ready, 1'b1);

    $display("%0d/%0d checks passed", pass_cnt, total_cnt);
    $finish;
  end

endmodule
